// File: rtl/div_pkg.sv
// Shared definitions for the 2N-by-N sequential radix-4 divider.
package div_pkg;
   localparam int DIV_N = 12;
   localparam int ITER_COUNT = DIV_N / 2;
   localparam logic [DIV_N-1:0] QUOT_SAT = '1;

   typedef enum logic [1:0] {
      IDLE,
      ITER,
      DONE
   } state_t;
endpackage

// File: rtl/div_radix4_step.sv
// One radix-4 restoring step: consumes two dividend bits and produces two quotient bits.
module div_radix4_step
   import div_pkg::*;
#(
   parameter int N = DIV_N
) (
   input  logic [N-1:0] rem_in,
   input  logic [1:0]   bits,
   input  logic [N-1:0] divisor,
   output logic [N-1:0] rem_out,
   output logic [1:0]   q_bits
);
   logic [N+1:0] pr, d1, d2, d3, diff;

   always_comb begin
      pr     = {rem_in, bits};
      d1     = {2'b00, divisor};
      d2     = {1'b0, divisor, 1'b0};
      d3     = d1 + d2;
      q_bits = 2'd0;
      diff   = pr;
      if (pr >= d3) begin
         q_bits = 2'd3;
         diff   = pr - d3;
      end else if (pr >= d2) begin
         q_bits = 2'd2;
         diff   = pr - d2;
      end else if (pr >= d1) begin
         q_bits = 2'd1;
         diff   = pr - d1;
      end
      // The restored remainder is always below the divisor, so it fits in N bits.
      rem_out = N'(diff);
   end
endmodule

// File: rtl/seq_divider_24by12.sv
// Sequential 2N/N radix-4 restoring divider with valid/ready handshakes.
// Define SEQ_DIVIDER_SIGNED_EN for two's-complement operands (truncating division).
module seq_divider_24by12
   import div_pkg::*;
#(
   parameter int N = DIV_N
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           in_valid,
   output logic           in_ready,
   input  logic [2*N-1:0] dividend,
   input  logic [N-1:0]   divisor,
   output logic           out_valid,
   input  logic           out_ready,
   output logic [N-1:0]   quotient,
   output logic [N-1:0]   remainder,
   output logic           div_by_zero,
   output logic           ovf
);
   localparam int CW = $clog2(N / 2 + 1);
   localparam logic [CW-1:0] CNT_INIT = CW'(N / 2 - 1);

   state_t        state, state_nx;
   logic [CW-1:0] cnt;
   logic [N-1:0]  dsr_r, rem_r, lo_r;
   logic [N-1:0]  step_rem;
   logic [1:0]    step_q;
   logic [2*N-1:0] dvd_u;
   logic [N-1:0]  dsr_u;
   logic          accept, err_zero, err_ovf;
   logic [N-1:0]  q_fin, q_out, r_out;
   logic          ovf_fin;

`ifdef SEQ_DIVIDER_SIGNED_EN
   logic neg_q, neg_r;
   assign dvd_u = dividend[2*N-1] ? -dividend : dividend;
   assign dsr_u = divisor[N-1] ? -divisor : divisor;
`else
   assign dvd_u = dividend;
   assign dsr_u = divisor;
`endif

   assign in_ready  = (state == IDLE);
   assign out_valid = (state == DONE);
   assign accept    = in_valid && in_ready;
   assign err_zero  = (divisor == '0);
   // A high half at or above the divisor means the quotient needs more than N bits.
   assign err_ovf   = !err_zero && (dvd_u[2*N-1:N] >= dsr_u);

   div_radix4_step #(.N(N)) u_step (
      .rem_in (rem_r),
      .bits   (lo_r[N-1:N-2]),
      .divisor(dsr_r),
      .rem_out(step_rem),
      .q_bits (step_q)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (accept) state_nx = (err_zero || err_ovf) ? DONE : ITER;
         ITER:    if (cnt == '0) state_nx = DONE;
         DONE:    if (out_ready) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // Quotient bits enter lo_r from the bottom as dividend bits leave the top.
   always_comb begin
      q_fin   = {lo_r[N-3:0], step_q};
      q_out   = q_fin;
      r_out   = step_rem;
      ovf_fin = 1'b0;
`ifdef SEQ_DIVIDER_SIGNED_EN
      if (neg_q) begin
         ovf_fin = (q_fin > {1'b1, {(N-1){1'b0}}});
         q_out   = -q_fin;
      end else begin
         ovf_fin = q_fin[N-1];
      end
      if (neg_r) r_out = -step_rem;
      if (ovf_fin) begin
         q_out = '1;
         r_out = '0;
      end
`endif
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt         <= '0;
         dsr_r       <= '0;
         rem_r       <= '0;
         lo_r        <= '0;
         quotient    <= '0;
         remainder   <= '0;
         div_by_zero <= 1'b0;
         ovf         <= 1'b0;
`ifdef SEQ_DIVIDER_SIGNED_EN
         neg_q       <= 1'b0;
         neg_r       <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: if (accept) begin
               dsr_r       <= dsr_u;
               rem_r       <= dvd_u[2*N-1:N];
               lo_r        <= dvd_u[N-1:0];
               cnt         <= CNT_INIT;
               div_by_zero <= err_zero;
               ovf         <= err_ovf;
`ifdef SEQ_DIVIDER_SIGNED_EN
               neg_q       <= dividend[2*N-1] ^ divisor[N-1];
               neg_r       <= dividend[2*N-1];
`endif
               if (err_zero || err_ovf) begin
                  quotient  <= '1;
                  remainder <= err_zero ? dividend[N-1:0] : '0;
               end
            end
            ITER: begin
               rem_r <= step_rem;
               lo_r  <= q_fin;
               if (cnt != '0) begin
                  cnt <= cnt - 1'b1;
               end else begin
                  quotient  <= q_out;
                  remainder <= r_out;
                  ovf       <= ovf_fin;
               end
            end
            default: ;
         endcase
      end
   end
endmodule
